// File: rtl/pci_pkg.sv
// Shared definitions for the PCI target sequencer: FSM state codes,
// memory command codes and the transfer-counter width helper.
package pci_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SKIP    = 3'd1;
  localparam logic [2:0] ST_DECODE  = 3'd2;
  localparam logic [2:0] ST_TURN    = 3'd3;
  localparam logic [2:0] ST_DATA    = 3'd4;
  localparam logic [2:0] ST_BACKOFF = 3'd5;
  localparam logic [2:0] ST_FINISH  = 3'd6;

  localparam logic [3:0] CMD_MEM_RD = 4'h6;
  localparam logic [3:0] CMD_MEM_WR = 4'h7;

  function automatic int xfer_cnt_w(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/pci_target_seq_if.sv
// Bus bundle between a PCI initiator and the target sequencer; the
// target uses the slave modport, a bench or initiator the master one.
interface pci_target_seq_if
  import pci_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 8
);

  logic                             frame;
  logic                             irdy;
  logic [DATA_W-1:0]                ad_in;
  logic [DATA_W/8-1:0]              cbe;
  logic                             devsel;
  logic                             trdy;
  logic                             stop;
  logic [DATA_W-1:0]                ad_out;
  logic                             ad_oe;
  logic [xfer_cnt_w(MAX_BURST)-1:0] xfer_count;
  logic [2:0]                       state;

  modport slave (
    input  frame, irdy, ad_in, cbe,
    output devsel, trdy, stop, ad_out, ad_oe, xfer_count, state
  );

  modport master (
    output frame, irdy, ad_in, cbe,
    input  devsel, trdy, stop, ad_out, ad_oe, xfer_count, state
  );

endinterface

// File: rtl/pci_regfile.sv
// Target register file: byte-enabled synchronous write, asynchronous
// read, cleared by synchronous reset.
module pci_regfile #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we_i,
  input  logic [DATA_W/8-1:0] be_i,
  input  logic [AW-1:0]       addr_i,
  input  logic [DATA_W-1:0]   wdata_i,
  output logic [DATA_W-1:0]   rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Storage update: reset clears every word, otherwise write enabled lanes.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      for (int b = 0; b < DATA_W/8; b++) begin
        if (be_i[b]) begin
          mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
        end
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/pci_target_seq.sv
// PCI memory target sequencer: address decode, devsel timing, read
// turnaround, burst data phases with target disconnect, register storage.
module pci_target_seq
  import pci_pkg::*;
#(
  parameter int          DATA_W     = 32,
  parameter int          DEPTH      = 16,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
  parameter int          DEVSEL_DLY = 1,
  parameter int          MAX_BURST  = 8
) (
  input logic              clk,
  input logic              rst,
  pci_target_seq_if.slave  bus
);

  localparam int                AW         = $clog2(DEPTH);
  localparam int                CW         = xfer_cnt_w(MAX_BURST);
  localparam logic [DATA_W-1:0] BASE_W     = DATA_W'(BASE_ADDR);
  localparam logic [CW-1:0]     BURST_LAST = CW'(MAX_BURST - 1);
  localparam logic [AW-1:0]     IDX_LAST   = AW'(DEPTH - 1);
  localparam logic [1:0]        DLY_LAST   = 2'(DEVSEL_DLY - 1);

  logic [2:0]        state_q, state_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              rd_q, rd_d;
  logic [1:0]        dly_q, dly_d;
  logic [3:0]        cmd_s;
  logic              hit_s, xfer_s, we_s;
  logic [DATA_W-1:0] rdata_s;
  logic              devsel_s, trdy_s, stop_s, ad_oe_s;

  assign cmd_s  = bus.cbe[3:0];
  assign hit_s  = ((cmd_s == CMD_MEM_RD) || (cmd_s == CMD_MEM_WR)) &&
                  (bus.ad_in[DATA_W-1:AW+2] == BASE_W[DATA_W-1:AW+2]);
  // trdy is always asserted in DATA, so a beat needs only irdy.
  assign xfer_s = (state_q == ST_DATA) && !bus.irdy;
  assign we_s   = xfer_s && !rd_q;

  // Next-state and datapath register computation.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    dly_d   = dly_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (!bus.frame) begin
          idx_d = bus.ad_in[AW+1:2];
          rd_d  = (cmd_s == CMD_MEM_RD);
          dly_d = 2'd0;
          if (!hit_s) begin
            state_d = ST_SKIP;
          end else if (DEVSEL_DLY != 0) begin
            state_d = ST_DECODE;
          end else if (cmd_s == CMD_MEM_RD) begin
            state_d = ST_TURN;
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SKIP: begin
        if (bus.frame && bus.irdy) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          state_d = ST_SKIP;
        end
      end
      ST_DECODE: begin
        if (dly_q == DLY_LAST) begin
          state_d = rd_q ? ST_TURN : ST_DATA;
        end else begin
          dly_d = dly_q + 2'd1;
        end
      end
      ST_TURN: begin
        state_d = ST_DATA;
      end
      ST_DATA: begin
        if (xfer_s) begin
          cnt_d = cnt_q + CW'(1);
          // idx saturates at the last word; the boundary forces a disconnect.
          if (idx_q != IDX_LAST) begin
            idx_d = idx_q + AW'(1);
          end else begin
            idx_d = idx_q;
          end
          if (bus.frame) begin
            state_d = ST_FINISH;
          end else if ((cnt_q == BURST_LAST) || (idx_q == IDX_LAST)) begin
            state_d = ST_BACKOFF;
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_BACKOFF: begin
        if (bus.frame) begin
          state_d = ST_FINISH;
        end else begin
          state_d = ST_BACKOFF;
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Sequencer state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      rd_q    <= 1'b0;
      dly_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      dly_q   <= dly_d;
    end
  end

  // Bus responses decoded purely from the registered state.
  always_comb begin
    devsel_s = 1'b1;
    trdy_s   = 1'b1;
    stop_s   = 1'b1;
    ad_oe_s  = 1'b0;
    case (state_q)
      ST_TURN: begin
        devsel_s = 1'b0;
      end
      ST_DATA: begin
        devsel_s = 1'b0;
        trdy_s   = 1'b0;
        ad_oe_s  = rd_q;
      end
      ST_BACKOFF: begin
        devsel_s = 1'b0;
        stop_s   = 1'b0;
      end
      default: begin
        devsel_s = 1'b1;
      end
    endcase
  end

  assign bus.devsel     = devsel_s;
  assign bus.trdy       = trdy_s;
  assign bus.stop       = stop_s;
  assign bus.ad_oe      = ad_oe_s;
  assign bus.ad_out     = rdata_s;
  assign bus.xfer_count = cnt_q;
  assign bus.state      = state_q;

  pci_regfile #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .we_i    (we_s),
    .be_i    (~bus.cbe),
    .addr_i  (idx_q),
    .wdata_i (bus.ad_in),
    .rdata_o (rdata_s)
  );

endmodule

// File: tb/tb_pci_target_seq.sv
// Randomized bench for pci_target_seq: an initiator drives transactions
// and a word-array memory model predicts every response.
module tb_pci_target_seq;

  localparam int          DATA_W     = 32;
  localparam int          DEPTH      = 16;
  localparam logic [31:0] BASE       = 32'h0000_1000;
  localparam int          DEVSEL_DLY = 1;
  localparam int          MAX_BURST  = 8;

  localparam logic [2:0] S_IDLE = 3'd0, S_SKIP = 3'd1, S_DECODE = 3'd2, S_TURN = 3'd3;
  localparam logic [2:0] S_DATA = 3'd4, S_BACKOFF = 3'd5, S_FINISH = 3'd6;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  logic [31:0] mem [DEPTH];
  logic [31:0] wdat [16];
  logic [3:0]  wbe  [16];

  pci_target_seq_if #(.DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) bus ();

  pci_target_seq #(
    .DATA_W     (DATA_W),
    .DEPTH      (DEPTH),
    .BASE_ADDR  (BASE),
    .DEVSEL_DLY (DEVSEL_DLY),
    .MAX_BURST  (MAX_BURST)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_resp(input string tag, input logic [2:0] st, input logic dv,
                            input logic tr, input logic sp, input logic oe);
    check({tag, "_state"},  64'(bus.state),  64'(st));
    check({tag, "_devsel"}, 64'(bus.devsel), 64'(dv));
    check({tag, "_trdy"},   64'(bus.trdy),   64'(tr));
    check({tag, "_stop"},   64'(bus.stop),   64'(sp));
    check({tag, "_ad_oe"},  64'(bus.ad_oe),  64'(oe));
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One initiator transaction; rst_beat >= 0 pulses reset during that beat.
  task automatic run_txn(input logic [31:0] addr, input logic [3:0] cmd,
                         input int nbeats, input int rst_beat);
    logic [31:0] base_v;
    bit          hit, rd;
    int          idx0, acc;
    base_v = BASE;
    hit  = ((cmd == 4'h6) || (cmd == 4'h7)) && (addr[31:6] == base_v[31:6]);
    rd   = (cmd == 4'h6);
    idx0 = int'(addr[5:2]);
    acc  = nbeats;
    if (acc > MAX_BURST) acc = MAX_BURST;
    if (acc > DEPTH - idx0) acc = DEPTH - idx0;

    bus.frame = 1'b0; bus.irdy = 1'b1; bus.ad_in = addr; bus.cbe = cmd;
    next_cycle();

    if (!hit) begin
      bus.frame = 1'b0; bus.irdy = 1'b0; bus.ad_in = $urandom; bus.cbe = 4'h0;
      for (int i = 0; i < nbeats; i++) begin
        @(negedge clk);
        check_resp("skip", S_SKIP, 1'b1, 1'b1, 1'b1, 1'b0);
        next_cycle();
      end
      bus.frame = 1'b1; bus.irdy = 1'b1;
      @(negedge clk);
      check_resp("skip_end", S_SKIP, 1'b1, 1'b1, 1'b1, 1'b0);
      next_cycle();
      @(negedge clk);
      check_resp("skip_idle", S_IDLE, 1'b1, 1'b1, 1'b1, 1'b0);
      return;
    end

    bus.irdy = 1'b1; bus.cbe = 4'hF; bus.ad_in = $urandom;
    for (int i = 0; i < DEVSEL_DLY; i++) begin
      @(negedge clk);
      check_resp("decode", S_DECODE, 1'b1, 1'b1, 1'b1, 1'b0);
      next_cycle();
    end
    if (rd) begin
      @(negedge clk);
      check_resp("turn", S_TURN, 1'b0, 1'b1, 1'b1, 1'b0);
      next_cycle();
    end

    for (int b = 0; b < acc; b++) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.irdy = 1'b1; bus.frame = 1'b0; bus.ad_in = $urandom; bus.cbe = 4'($urandom);
        @(negedge clk);
        check_resp("wait", S_DATA, 1'b0, 1'b0, 1'b1, rd);
        check("wait_count", 64'(bus.xfer_count), 64'(b));
        if (rd) check("wait_ad_out", 64'(bus.ad_out), 64'(mem[idx0 + b]));
        next_cycle();
      end
      bus.irdy  = 1'b0;
      bus.frame = (b == nbeats - 1);
      bus.ad_in = rd ? $urandom : wdat[b];
      bus.cbe   = rd ? 4'h0 : wbe[b];
      @(negedge clk);
      check_resp("beat", S_DATA, 1'b0, 1'b0, 1'b1, rd);
      check("beat_count", 64'(bus.xfer_count), 64'(b));
      if (rd) check("beat_ad_out", 64'(bus.ad_out), 64'(mem[idx0 + b]));
      if (b == rst_beat) begin
        rst = 1'b1;
        next_cycle();
        rst = 1'b0; bus.frame = 1'b1; bus.irdy = 1'b1;
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'h0;
        @(negedge clk);
        check_resp("rst_mid", S_IDLE, 1'b1, 1'b1, 1'b1, 1'b0);
        check("rst_mid_count", 64'(bus.xfer_count), 64'd0);
        return;
      end
      next_cycle();
      if (!rd) begin
        for (int l = 0; l < 4; l++) begin
          if (!wbe[b][l]) mem[idx0 + b][l*8 +: 8] = wdat[b][l*8 +: 8];
        end
      end
    end

    if (acc < nbeats) begin
      bus.frame = 1'b0; bus.irdy = 1'b1;
      @(negedge clk);
      check_resp("backoff", S_BACKOFF, 1'b0, 1'b1, 1'b0, 1'b0);
      check("backoff_count", 64'(bus.xfer_count), 64'(acc));
      next_cycle();
      bus.frame = 1'b1; bus.irdy = 1'b1;
      @(negedge clk);
      check_resp("backoff_hold", S_BACKOFF, 1'b0, 1'b1, 1'b0, 1'b0);
      next_cycle();
    end
    bus.frame = 1'b1; bus.irdy = 1'b1;
    @(negedge clk);
    check_resp("finish", S_FINISH, 1'b1, 1'b1, 1'b1, 1'b0);
    check("finish_count", 64'(bus.xfer_count), 64'(acc));
    next_cycle();
    @(negedge clk);
    check_resp("idle", S_IDLE, 1'b1, 1'b1, 1'b1, 1'b0);
    check("idle_count", 64'(bus.xfer_count), 64'd0);
  endtask

  task automatic read_all();
    run_txn(32'h0000_1000, 4'h6, 8, -1);
    run_txn(32'h0000_1020, 4'h6, 8, -1);
  endtask

  initial begin
    logic [31:0] base_v;
    logic [31:0] addr;
    logic [3:0]  cmd;
    int          sel;
    n_checks = 0;
    n_errors = 0;
    base_v = BASE;
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'h0;
    for (int i = 0; i < 16; i++) begin wdat[i] = 32'h0; wbe[i] = 4'h0; end
    rst = 1'b1; bus.frame = 1'b1; bus.irdy = 1'b1; bus.ad_in = 32'h0; bus.cbe = 4'hF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_resp("reset", S_IDLE, 1'b1, 1'b1, 1'b1, 1'b0);
    check("reset_count", 64'(bus.xfer_count), 64'd0);
    next_cycle();
    rst = 1'b0;
    read_all();

    // Single-beat write of word 1, then read it back through the turnaround.
    wdat[0] = 32'hDEAD_BEEF; wbe[0] = 4'h0;
    run_txn(32'h0000_1004, 4'h7, 1, -1);
    run_txn(32'h0000_1004, 4'h6, 1, -1);

    wdat[0] = 32'hA5A5_0001; wdat[1] = 32'h0000_0002; wbe[0] = 4'h0; wbe[1] = 4'h0;
    run_txn(32'h0000_1008, 4'h7, 2, -1);
    run_txn(32'h0000_1008, 4'h6, 2, -1);

    // Ten-beat write is cut at MAX_BURST; beats 9 and 10 must not land.
    for (int i = 0; i < 10; i++) begin wdat[i] = 32'h5000_0000 + 32'(i); wbe[i] = 4'h0; end
    run_txn(32'h0000_1000, 4'h7, 10, -1);
    read_all();

    // End-of-file boundary, with and without a simultaneous frame release.
    run_txn(32'h0000_1034, 4'h7, 3, -1);
    run_txn(32'h0000_1034, 4'h7, 4, -1);
    read_all();

    wdat[0] = 32'h1234_5678;
    run_txn(32'h0000_2000, 4'h7, 2, -1);
    run_txn(32'h0000_1000, 4'h2, 2, -1);
    read_all();

    run_txn(32'h0000_1000, 4'h6, 4, 1);
    read_all();
    wdat[0] = 32'hFFFF_FFFF; wbe[0] = 4'b1110;
    run_txn(32'h0000_1000, 4'h7, 1, -1);
    run_txn(32'h0000_1000, 4'h6, 1, -1);

    for (int t = 0; t < 40; t++) begin
      sel  = $urandom_range(0, 9);
      addr = {base_v[31:6], 4'($urandom_range(0, 15)), 2'b00};
      cmd  = ($urandom_range(0, 1) == 0) ? 4'h6 : 4'h7;
      if (sel == 0) addr = 32'h0000_2000 + {26'($urandom_range(0, 15)), 6'h0};
      if (sel == 1) cmd = 4'($urandom_range(0, 5));
      for (int i = 0; i < 16; i++) begin
        wdat[i] = $urandom;
        wbe[i]  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      end
      run_txn(addr, cmd, $urandom_range(1, 10), -1);
    end
    read_all();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
